// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [3:0] AdjustThreshold = 4'd5;
    localparam logic [3:0] AdjustOffset    = 4'd3;

    // ceil(width * log10(2)) with log10(2) taken as 0.30103
    function automatic int unsigned digits_for_width(input int unsigned width);
        longint unsigned scaled;
        scaled = 64'(width) * 64'd30103 + 64'd99999;
        return 32'(scaled / 64'd100000);
    endfunction

    // Counter must hold the value WIDTH itself
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 32'd1);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= AdjustThreshold) ? (digit + AdjustOffset) : digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble converter: one operand bit per clock, start/done handshake,
// optional two's-complement input reported as sign plus magnitude.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  negative,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    if (WIDTH < 4) begin : g_width_check
        $error("bcd_seq_converter: WIDTH must be at least 4");
    end
    if (DIGITS < digits_for_width(WIDTH)) begin : g_digits_check
        $error("bcd_seq_converter: DIGITS too small for WIDTH");
    end

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [4*DIGITS-1:0] scratch_q, scratch_d;
    logic [4*DIGITS-1:0] adjusted;
    logic                sign_q, sign_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                neg_q, neg_d;

    logic                is_neg;
    logic [WIDTH-1:0]    magnitude;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit    (scratch_q[4*k +: 4]),
            .adjusted (adjusted[4*k +: 4])
        );
    end

    // WIDTH-bit negation: the most negative value maps onto 2^(WIDTH-1) as unsigned
    assign is_neg    = signed_mode & bin_in[WIDTH-1];
    assign magnitude = is_neg ? -bin_in : bin_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        sign_d    = sign_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d   = StShift;
                    shift_d   = magnitude;
                    sign_d    = is_neg;
                    scratch_d = '0;
                    cnt_d     = CntW'(WIDTH);
                end
            end
            StShift: begin
                {scratch_d, shift_d} = {adjusted, shift_q} << 1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    bcd_d   = scratch_d;
                    neg_d   = sign_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
        end
    end

    assign ready    = (state_q != StShift);
    assign busy     = (state_q == StShift);
    assign done     = (state_q == StDone);
    assign negative = neg_q;
    assign bcd_out  = bcd_q;

endmodule
